synchronous_fifo: RTL
=====================

# synchronous_fifo

Single-clock FIFO for buffering packet words inside one clock domain of the switch: port ingress staging, crossbar output queues, and anywhere the dual-clock FIFO's synchroniser latency is wasted. Parameterised in width and depth, with a selectable output mode (standard or first-word-fall-through), programmable almost-full/almost-empty thresholds, and an exact occupancy count. Storage is the team's generic dual-port RAM with both ports on one clock.

## Interface
- DATA_WIDTH, 16, word width in bits
- DATA_DEPTH, 4096, storage words; power of two, minimum 4
- FIRST_WORD_FALL_THROUGH, 0, 0 = standard read, 1 = head word presented without a read request
- ALMOST_FULL_THRESHOLD, DATA_DEPTH-4, almost_full asserts when count >= this value
- ALMOST_EMPTY_THRESHOLD, 4, almost_empty asserts when count <= this value
- clock  input  1  single clock for the whole block
- reset_n  input  1  synchronous, active-low reset
- write_enable  input  1  write request
- write_data  input  DATA_WIDTH  word to enqueue
- read_enable  input  1  read request (standard mode) or pop (FWFT mode)
- read_data  output  DATA_WIDTH  dequeued word
- read_data_valid  output  1  read_data qualifier
- full  output  1  no free entry
- empty  output  1  no readable word
- almost_full  output  1  count >= ALMOST_FULL_THRESHOLD
- almost_empty  output  1  count <= ALMOST_EMPTY_THRESHOLD
- count  output  $clog2(DATA_DEPTH)+1  words held, including any FWFT output word
- overflow  output  1  sticky: a write was dropped
- underflow  output  1  sticky: a read was dropped

## Operation
- Pointers are binary, $clog2(DATA_DEPTH)+1 bits wide. The MSB is a wrap bit. Address = pointer LSBs; pointers wrap naturally modulo 2·DATA_DEPTH.
- A write is accepted when write_enable is high and either full is low or, in standard mode only, an accepted read occurs in the same cycle. Accepted writes store to RAM and increment the write pointer.
- A read is accepted when read_enable is high and empty is low.
- count updates each cycle as: +1 on an accepted write, −1 on an accepted read, 0 when both or neither occur.
- full is (count == DATA_DEPTH). empty in standard mode is (count == 0). In FWFT mode, empty is !read_data_valid.
- Standard mode: an accepted read drives read_data to the head word after the next edge, with read_data_valid high for exactly one cycle. read_data holds its value otherwise.
- FWFT mode uses an internal prefetch FSM with states IDLE, FETCH and PRESENT:
  - IDLE → FETCH when the RAM holds an unfetched word.
  - FETCH → PRESENT: read_data loads the word and read_data_valid rises.
  - PRESENT: on a pop, if another word is available, the next word is loaded back-to-back with no bubble; otherwise the FSM returns to IDLE.
- In FWFT mode with the FIFO full, a simultaneous write and pop accepts the pop only; the write is dropped.
- A dropped write (write_enable high, not accepted) sets overflow. A read with empty high sets underflow. Both flags clear only on reset.
- Reset mid-operation discards all contents. No RAM clearing is required.

## Timing
- Reset values: read_data 0, read_data_valid 0, full 0, empty 1, almost_full 0, almost_empty 1, count 0, overflow 0, underflow 0, both pointers 0, FSM IDLE.
- All outputs are registered.
- Write accepted at edge N: count, full, almost_full and almost_empty reflect it after edge N.
- Standard mode: empty deasserts after edge N. A read accepted at edge M gives read_data and read_data_valid after edge M+1 (latency 1).
- FWFT mode: a write into an empty FIFO at edge N gives read_data_valid high after edge N+2. Sustained pops return one word per cycle.
- Full throughput: one write and one read every cycle, indefinitely, with no bubbles in either mode.

## Configuration
- SYNCHRONOUS_FIFO_ERROR_FLAGS_EN
  - Defined: overflow and underflow behave as described above.
  - Undefined: both outputs are tied to 0, their registers are not built, and data behaviour is unchanged.

## Test plan
- Reset, then idle → every output at its reset value; count 0; empty 1; almost_empty 1.
- DATA_DEPTH 8, standard mode; write 0x0001–0x0008 on consecutive cycles → full after the 8th edge, count 8, almost_full 1. Then read 8 times → 0x0001–0x0008 in order, one valid per read, empty after the last.
- Full FIFO, standard mode; write 0x00AA with read_enable in the same cycle → both accepted, count stays 8, 0x00AA read out last. Repeat in FWFT mode → write dropped, overflow 1 (macro defined).
- FWFT mode, empty; write 0x1234 at edge N → read_data 0x1234 with read_data_valid 1 after edge N+2, before any read_enable. Pop → empty after the next edge.
- Simultaneous write and read every cycle for 3·DATA_DEPTH cycles across pointer wrap → data returned in order and count constant.
- read_enable while empty → underflow 1, count stays 0. Pulse reset_n low mid-stream → all outputs at reset values after that edge, and the flags clear.

Source files
------------

// File: rtl/synchronous_fifo_if.sv
// Handshake bundle for synchronous_fifo: write request, read request, read data
// and all status flags. The FIFO connects through the slave modport.
interface synchronous_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4096
);
    localparam int COUNT_WIDTH = $clog2(DATA_DEPTH) + 1;

    logic                   write_enable;
    logic [DATA_WIDTH-1:0]  write_data;
    logic                   read_enable;
    logic [DATA_WIDTH-1:0]  read_data;
    logic                   read_data_valid;
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   almost_empty;
    logic [COUNT_WIDTH-1:0] count;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output write_enable, write_data, read_enable,
        input  read_data, read_data_valid, full, empty, almost_full,
               almost_empty, count, overflow, underflow
    );

    modport slave (
        input  write_enable, write_data, read_enable,
        output read_data, read_data_valid, full, empty, almost_full,
               almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read mode and
// registered status flags. Define SYNCHRONOUS_FIFO_ERROR_FLAGS_EN to build the sticky overflow/underflow flags.
module synchronous_fifo #(
    parameter int DATA_WIDTH              = 16,
    parameter int DATA_DEPTH              = 4096,
    parameter int FIRST_WORD_FALL_THROUGH = 0,
    parameter int ALMOST_FULL_THRESHOLD   = DATA_DEPTH - 4,
    parameter int ALMOST_EMPTY_THRESHOLD  = 4
) (
    input logic               clock,
    input logic               reset_n,
    synchronous_fifo_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam bit FWFT       = (FIRST_WORD_FALL_THROUGH != 0);

    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] DEPTH_C  = PTR_WIDTH'(DATA_DEPTH);
    localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(ALMOST_FULL_THRESHOLD);
    localparam logic [PTR_WIDTH-1:0] AE_LEVEL = PTR_WIDTH'(ALMOST_EMPTY_THRESHOLD);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // ram_q is the RAM's registered read port; ram_q_valid marks it as holding
    // a word not yet moved to read_data.
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  ram_q_valid;

    state_t                state;
    state_t                state_next;

    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  read_data_valid_q;
    logic                  full_q;
    logic                  empty_q;
    logic                  almost_full_q;
    logic                  almost_empty_q;
    logic [PTR_WIDTH-1:0]  count_q;

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  unfetched;
    logic                  ram_read;
    logic                  out_load;
    logic                  ram_q_valid_next;
    logic                  valid_next;
    logic                  empty_next;
    logic [PTR_WIDTH-1:0]  count_next;

    assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        unfetched  = (wr_ptr != rd_ptr);
        rd_accept  = bus.read_enable && !empty_q;
        state_next = state;
        out_load   = 1'b0;
        ram_read   = 1'b0;
        valid_next = 1'b0;
        empty_next = 1'b1;

        // A full standard FIFO can still take a write when the same edge frees a slot.
        if (FWFT) begin
            wr_accept = bus.write_enable && !full_q;
        end else begin
            wr_accept = bus.write_enable && (!full_q || rd_accept);
        end

        count_next = count_q + (wr_accept ? PTR_ONE : '0) - (rd_accept ? PTR_ONE : '0);

        if (FWFT) begin
            out_load = ram_q_valid && ((state == FETCH) || ((state == PRESENT) && rd_accept));
            ram_read = unfetched && (!ram_q_valid || out_load);

            case (state)
                IDLE: begin
                    if (unfetched) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    state_next = PRESENT;
                end
                PRESENT: begin
                    if (rd_accept) begin
                        if (ram_q_valid) begin
                            state_next = PRESENT;
                        end else if (unfetched) begin
                            state_next = FETCH;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            valid_next = (state_next == PRESENT);
            empty_next = !valid_next;
        end else begin
            out_load   = ram_q_valid;
            ram_read   = rd_accept;
            valid_next = ram_q_valid;
            empty_next = (count_next == '0);
        end

        ram_q_valid_next = ram_read || (ram_q_valid && !out_load);
    end

    // NOTE: the storage array has no reset; pointers and valid bits alone define its contents.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wr_addr] <= bus.write_data;
        end
        if (ram_read) begin
            ram_q <= mem[rd_addr];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            ram_q_valid       <= 1'b0;
            state             <= IDLE;
            read_data_q       <= '0;
            read_data_valid_q <= 1'b0;
            full_q            <= 1'b0;
            empty_q           <= 1'b1;
            almost_full_q     <= 1'b0;
            almost_empty_q    <= 1'b1;
            count_q           <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_read) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (out_load) begin
                read_data_q <= ram_q;
            end
            ram_q_valid       <= ram_q_valid_next;
            state             <= state_next;
            read_data_valid_q <= valid_next;
            count_q           <= count_next;
            full_q            <= (count_next == DEPTH_C);
            empty_q           <= empty_next;
            almost_full_q     <= (count_next >= AF_LEVEL);
            almost_empty_q    <= (count_next <= AE_LEVEL);
        end
    end

    assign bus.read_data       = read_data_q;
    assign bus.read_data_valid = read_data_valid_q;
    assign bus.full            = full_q;
    assign bus.empty           = empty_q;
    assign bus.almost_full     = almost_full_q;
    assign bus.almost_empty    = almost_empty_q;
    assign bus.count           = count_q;

`ifdef SYNCHRONOUS_FIFO_ERROR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.write_enable && !wr_accept) begin
                overflow_q <= 1'b1;
            end
            if (bus.read_enable && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule
